regfile_scoreboard: RTL and testbench

//   Parametrised multi-read-port register file for the ID stage, with a write-through bypass and a per-register pending scoreboard.

---
 rtl/regfile_scoreboard.sv | 105 ++++++++++
 tb/tb_regfile_scoreboard.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register in-flight producer counters and an ID stall.
// Optional macro REGFILE_BYPASS_EN: write-through bypass on reads plus the last-producer pending exception.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_use,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  output logic                     stall,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_dst,
  output logic                     iss_ready,
  input  logic                     flush
);

  localparam int               DEPTH    = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_reg [DEPTH];
  logic [CNT_W-1:0]  cnt_reg  [DEPTH];
  logic [CNT_W-1:0]  cnt_next [DEPTH];

  logic wr_fire;
  logic iss_zero;
  logic iss_fire;
  logic iss_ready_int;

  assign wr_fire  = wr_en && !(HAS_ZERO && wr_addr == '0);
  assign iss_zero = HAS_ZERO && iss_dst == '0;

  // A saturated counter may still accept an issue when its writeback retires a producer this cycle.
  assign iss_ready_int = iss_zero || (cnt_reg[iss_dst] != CNT_MAX) || (wr_en && wr_addr == iss_dst);
  assign iss_ready     = iss_ready_int;
  assign iss_fire      = iss_valid && iss_ready_int && !iss_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
        cnt_reg[i]  <= '0;
      end
    end else begin
      if (wr_fire) begin
        regs_reg[wr_addr] <= wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  // Issue and retire on the same register cancel; retire at zero is absorbed.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next[i] = cnt_reg[i];
      if (flush) begin
        cnt_next[i] = '0;
      end else if (iss_fire && iss_dst == ADDR_W'(i) && !(wr_fire && wr_addr == ADDR_W'(i))) begin
        cnt_next[i] = cnt_reg[i] + CNT_ONE;
      end else if (wr_fire && wr_addr == ADDR_W'(i) && !(iss_fire && iss_dst == ADDR_W'(i))
                   && cnt_reg[i] != '0) begin
        cnt_next[i] = cnt_reg[i] - CNT_ONE;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              addr_zero;
      logic              bypass_hit;
      logic [CNT_W-1:0]  cnt_at;

      assign addr      = rd_addr[gi*ADDR_W +: ADDR_W];
      assign addr_zero = HAS_ZERO && addr == '0;
      assign cnt_at    = cnt_reg[addr];
`ifdef REGFILE_BYPASS_EN
      assign bypass_hit = wr_en && wr_addr == addr;
`else
      assign bypass_hit = 1'b0;
`endif
      assign rd_data[gi*DATA_W +: DATA_W] = (!rst_n || addr_zero) ? '0 :
                                            bypass_hit ? wr_data : regs_reg[addr];
      // The last producer being written back this cycle is already forwarded, so it does not stall.
      assign rd_pending[gi] = rst_n && !addr_zero && (cnt_at != '0)
                              && !(bypass_hit && cnt_at == CNT_ONE);
    end
  endgenerate

  assign stall = |(rd_use & rd_pending);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        stall;
  logic        iss_valid;
  logic [4:0]  iss_dst;
  logic        iss_ready;
  logic        flush;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp32;
  logic        exp1;
  logic [1:0]  exp2;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_use(rd_use), .rd_data(rd_data),
    .rd_pending(rd_pending), .stall(stall),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5_A5A5;
    step();
    wr_en = 1'b0; iss_valid = 1'b1; iss_dst = 5'd5;
    step();
    iss_valid = 1'b0; rd_addr = {5'd0, 5'd5}; rd_use = 2'b01; #1;
    n_total++; if (rd_pending !== 2'b01) $display("FAIL pre_reset_pending: got %b expected %b", rd_pending, 2'b01); else n_pass++;
    n_total++; if (rd_data[31:0] !== 32'hA5A5_A5A5) $display("FAIL pre_reset_data: got %h expected %h", rd_data[31:0], 32'hA5A5_A5A5); else n_pass++;
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0077; #1;
    n_total++; if (rd_data !== 64'h0) $display("FAIL reset_rd_data: got %h expected %h", rd_data, 64'h0); else n_pass++;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL reset_pending: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected %b", stall, 1'b0); else n_pass++;
    n_total++; if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready: got %b expected %b", iss_ready, 1'b1); else n_pass++;
    wr_en = 1'b0; #2; rst_n = 1'b1; rd_use = 2'b00;
    step();
    n_total++; if (rd_data[31:0] !== 32'h0) $display("FAIL reset_reg5: got %h expected %h", rd_data[31:0], 32'h0); else n_pass++;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL reset_reg5_pending: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    $display("reset: done");
  endtask

  task automatic test_write();
    rd_addr = {5'd3, 5'd3}; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF; #1;
    exp32 = BYP ? 32'hDEAD_BEEF : 32'h0;
    n_total++; if (rd_data[31:0] !== exp32) $display("FAIL write_same_cycle: got %h expected %h", rd_data[31:0], exp32); else n_pass++;
    step();
    wr_en = 1'b0; #1;
    n_total++; if (rd_data !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) $display("FAIL write_next_cycle: got %h expected %h", rd_data, {32'hDEAD_BEEF, 32'hDEAD_BEEF}); else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234; rd_addr = {5'd3, 5'd0}; #1;
    n_total++; if (rd_data[31:0] !== 32'h0) $display("FAIL zero_reg_same_cycle: got %h expected %h", rd_data[31:0], 32'h0); else n_pass++;
    step();
    wr_en = 1'b0; #1;
    n_total++; if (rd_data !== {32'hDEAD_BEEF, 32'h0}) $display("FAIL zero_reg_after: got %h expected %h", rd_data, {32'hDEAD_BEEF, 32'h0}); else n_pass++;
    $display("write: done");
  endtask

  task automatic test_pending();
    iss_valid = 1'b1; iss_dst = 5'd7; #1;
    n_total++; if (iss_ready !== 1'b1) $display("FAIL issue7_ready: got %b expected %b", iss_ready, 1'b1); else n_pass++;
    step();
    iss_valid = 1'b0; rd_addr = {5'd0, 5'd7}; rd_use = 2'b00; #1;
    n_total++; if (rd_pending !== 2'b01) $display("FAIL pending7: got %b expected %b", rd_pending, 2'b01); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL stall_unused: got %b expected %b", stall, 1'b0); else n_pass++;
    rd_use = 2'b01; #1;
    n_total++; if (stall !== 1'b1) $display("FAIL stall_used: got %b expected %b", stall, 1'b1); else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55; #1;
    exp1 = BYP ? 1'b0 : 1'b1; exp32 = BYP ? 32'h55 : 32'h0;
    n_total++; if (stall !== exp1) $display("FAIL stall_wb_cycle: got %b expected %b", stall, exp1); else n_pass++;
    n_total++; if (rd_data[31:0] !== exp32) $display("FAIL data_wb_cycle: got %h expected %h", rd_data[31:0], exp32); else n_pass++;
    step();
    wr_en = 1'b0; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL stall_after_wb: got %b expected %b", stall, 1'b0); else n_pass++;
    n_total++; if (rd_data[31:0] !== 32'h55) $display("FAIL data_after_wb: got %h expected %h", rd_data[31:0], 32'h55); else n_pass++;
    rd_use = 2'b00;
    $display("pending: done");
  endtask

  task automatic test_saturate();
    rd_addr = {5'd0, 5'd9}; iss_dst = 5'd9; iss_valid = 1'b1;
    step(); step(); step();
    n_total++; if (iss_ready !== 1'b0) $display("FAIL sat_ready_after3: got %b expected %b", iss_ready, 1'b0); else n_pass++;
    step();
    n_total++; if (iss_ready !== 1'b0) $display("FAIL sat_4th_ignored: got %b expected %b", iss_ready, 1'b0); else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; #1;
    n_total++; if (iss_ready !== 1'b1) $display("FAIL sat_ready_with_wb: got %b expected %b", iss_ready, 1'b1); else n_pass++;
    step();
    wr_en = 1'b0; iss_valid = 1'b0; #1;
    n_total++; if (iss_ready !== 1'b0) $display("FAIL sat_stays3: got %b expected %b", iss_ready, 1'b0); else n_pass++;
    wr_en = 1'b1; step(); wr_en = 1'b0; #1;
    n_total++; if (rd_pending !== 2'b01) $display("FAIL drain_cnt2: got %b expected %b", rd_pending, 2'b01); else n_pass++;
    wr_en = 1'b1; step(); wr_en = 1'b0; #1;
    n_total++; if (rd_pending !== 2'b01) $display("FAIL drain_cnt1: got %b expected %b", rd_pending, 2'b01); else n_pass++;
    wr_en = 1'b1; #1;
    exp2 = BYP ? 2'b00 : 2'b01;
    n_total++; if (rd_pending !== exp2) $display("FAIL last_producer_wb: got %b expected %b", rd_pending, exp2); else n_pass++;
    step();
    wr_en = 1'b0; #1;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL drain_cnt0: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    $display("saturate: done");
  endtask

  task automatic test_same_cycle();
    rd_addr = {5'd0, 5'd4}; iss_dst = 5'd4; iss_valid = 1'b1;
    step();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    step();
    iss_valid = 1'b0; wr_en = 1'b0; #1;
    n_total++; if (rd_pending !== 2'b01) $display("FAIL iss_wb_same_reg: got %b expected %b", rd_pending, 2'b01); else n_pass++;
    wr_en = 1'b1; step(); wr_en = 1'b0; #1;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL wb_to_zero: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    wr_en = 1'b1; step(); wr_en = 1'b0; #1;
    n_total++; if (iss_ready !== 1'b1) $display("FAIL no_underflow_ready: got %b expected %b", iss_ready, 1'b1); else n_pass++;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL no_underflow_pending: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    iss_valid = 1'b1; iss_dst = 5'd11;
    step();
    iss_dst = 5'd10; wr_en = 1'b1; wr_addr = 5'd11;
    step();
    iss_valid = 1'b0; wr_en = 1'b0; rd_addr = {5'd11, 5'd10}; #1;
    n_total++; if (rd_pending !== 2'b01) $display("FAIL independent_regs: got %b expected %b", rd_pending, 2'b01); else n_pass++;
    $display("same_cycle: done");
  endtask

  task automatic test_flush();
    iss_valid = 1'b1;
    iss_dst = 5'd2; step();
    iss_dst = 5'd6; step();
    iss_dst = 5'd8; step();
    iss_valid = 1'b0; rd_addr = {5'd6, 5'd2}; #1;
    n_total++; if (rd_pending !== 2'b11) $display("FAIL pre_flush_pending: got %b expected %b", rd_pending, 2'b11); else n_pass++;
    flush = 1'b1; iss_valid = 1'b1; iss_dst = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hCAFE_F00D;
    step();
    flush = 1'b0; iss_valid = 1'b0; wr_en = 1'b0; #1;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL flush_2_6: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    rd_addr = {5'd10, 5'd8}; #1;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL flush_8_10: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    rd_addr = {5'd12, 5'd2}; #1;
    n_total++; if (rd_data[63:32] !== 32'hCAFE_F00D) $display("FAIL flush_wb_stored: got %h expected %h", rd_data[63:32], 32'hCAFE_F00D); else n_pass++;
    iss_valid = 1'b1; iss_dst = 5'd0; #1;
    n_total++; if (iss_ready !== 1'b1) $display("FAIL zero_iss_ready: got %b expected %b", iss_ready, 1'b1); else n_pass++;
    step();
    iss_valid = 1'b0; rd_addr = {5'd0, 5'd0}; rd_use = 2'b11; #1;
    n_total++; if (rd_pending !== 2'b00) $display("FAIL zero_never_pending: got %b expected %b", rd_pending, 2'b00); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL zero_no_stall: got %b expected %b", stall, 1'b0); else n_pass++;
    rd_use = 2'b00;
    $display("flush: done");
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; rd_use = '0; iss_valid = 1'b0; iss_dst = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    test_reset();
    test_write();
    test_pending();
    test_saturate();
    test_same_cycle();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
